// File: rtl/qed_dup_encoder.sv
// rtl/qed_dup_encoder.sv - QED EDDI-V duplicate instruction encoder
//
// Passes original LW/SW/ALU-imm/ALU-reg instructions through to the core and
// queues their register- and memory-remapped duplicates. The queued duplicates
// are replayed in program order on flush or when the queue fills.
//
// Optional feature macro: QED_ILLEGAL_CNT_EN adds the illegal_count output.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready original instruction handshake, in_instruction payload
//   flush             single-cycle drain request
//   out_valid/out_ready, out_instruction, out_is_dup  instruction to the core
//   dup_count         duplicate queue occupancy
//   illegal_flag      sticky, an unsupported or out-of-range original was seen
//   illegal_count     (QED_ILLEGAL_CNT_EN) saturating count of illegal originals
module qed_dup_encoder #(
  parameter int          DEPTH      = 8,
  parameter logic [11:0] MEM_OFFSET = 12'h400
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_instruction,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_instruction,
  output logic                     out_is_dup,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   dup_count,
`ifdef QED_ILLEGAL_CNT_EN
  output logic [15:0]              illegal_count,
`endif
  output logic                     illegal_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {ORIG, DRAIN} state_t;

  state_t         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [31:0]    out_instr_q, out_instr_d;
  logic           out_is_dup_q, out_is_dup_d;
  logic           illegal_q, illegal_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [31:0]    mem_q [DEPTH];

  // Decode of the offered original
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        is_lw, is_sw, is_alui, is_alur, supported;
  logic        uses_rd, uses_rs2, legal;
  logic [11:0] mem_imm;
  logic [31:0] dup_instr;

  function automatic logic [4:0] remap(input logic [4:0] r);
    return (r == 5'd0) ? r : (r | 5'd16);
  endfunction

  always_comb begin
    opcode    = in_instruction[6:0];
    rd        = in_instruction[11:7];
    funct3    = in_instruction[14:12];
    rs1       = in_instruction[19:15];
    rs2       = in_instruction[24:20];
    is_lw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
    is_sw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
    is_alui   = (opcode == 7'b0010011);
    is_alur   = (opcode == 7'b0110011);
    supported = is_lw || is_sw || is_alui || is_alur;
    uses_rd   = is_lw || is_alui || is_alur;
    uses_rs2  = is_sw || is_alur;
    // Only x0..x15 are legal in originals; x16..x31 are reserved for duplicates.
    legal     = supported && !(uses_rd && rd[4]) && !rs1[4] && !(uses_rs2 && rs2[4]);

    mem_imm   = (is_sw ? {in_instruction[31:25], in_instruction[11:7]}
                       : in_instruction[31:20]) + MEM_OFFSET;

    dup_instr        = in_instruction;
    dup_instr[19:15] = remap(rs1);
    if (uses_rd)  dup_instr[11:7]  = remap(rd);
    if (uses_rs2) dup_instr[24:20] = remap(rs2);
    if (is_lw)    dup_instr[31:20] = mem_imm;
    if (is_sw) begin
      dup_instr[31:25] = mem_imm[11:5];
      dup_instr[11:7]  = mem_imm[4:0];
    end
  end

  logic          load_en, fifo_full, accept, push, pop;
  logic [CW-1:0] count_after;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_is_dup_d = out_is_dup_q;
    illegal_d    = illegal_q;
    in_ready     = 1'b0;
    accept       = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    load_en      = !out_valid_q || out_ready;
    fifo_full    = (count_q == CW'(DEPTH));
    count_after  = count_q;

    case (state_q)
      ORIG: begin
        in_ready = !fifo_full && load_en;
        accept   = in_valid && in_ready;
        if (accept) begin
          out_valid_d  = 1'b1;
          out_is_dup_d = 1'b0;
          out_instr_d  = legal ? in_instruction : NOP;
          push         = legal;
          if (!legal) illegal_d = 1'b1;
        end else if (load_en) begin
          out_valid_d = 1'b0;
        end
        count_after = push ? count_q + CW'(1) : count_q;
        if ((flush && count_after != '0) || count_after == CW'(DEPTH))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (load_en) begin
          if (count_q != '0) begin
            pop          = 1'b1;
            out_valid_d  = 1'b1;
            out_is_dup_d = 1'b1;
            out_instr_d  = mem_q[rd_ptr_q];
            if (count_q == CW'(1)) state_d = ORIG;
          end else begin
            out_valid_d = 1'b0;
            state_d     = ORIG;
          end
        end
      end
      default: state_d = ORIG;
    endcase

    count_d = count_q;
    if (push)     count_d = count_q + CW'(1);
    else if (pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ORIG;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_is_dup_q <= 1'b0;
      illegal_q    <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_is_dup_q <= out_is_dup_d;
      illegal_q    <= illegal_d;
      count_q      <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Queue storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dup_instr;
  end

`ifdef QED_ILLEGAL_CNT_EN
  logic [15:0] illegal_count_q, illegal_count_d;

  always_comb begin
    illegal_count_d = illegal_count_q;
    if (accept && !legal && illegal_count_q != 16'hFFFF)
      illegal_count_d = illegal_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) illegal_count_q <= '0;
    else     illegal_count_q <= illegal_count_d;
  end

  assign illegal_count = illegal_count_q;
`endif

  assign out_valid       = out_valid_q;
  assign out_instruction = out_instr_q;
  assign out_is_dup      = out_is_dup_q;
  assign dup_count       = count_q;
  assign illegal_flag    = illegal_q;

endmodule
